// File: rtl/ttt_pkg.sv
// ttt_pkg: shared encodings and sizes for the tic-tac-toe game sequencer
package ttt_pkg;
  localparam int NUM_CELLS = 9;
  localparam int NUM_LINES = 8;
  typedef logic [NUM_CELLS-1:0] board_t;
  localparam logic [1:0] ST_PLAY  = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_A    = 2'b01;
  localparam logic [1:0] WIN_B    = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;
  localparam logic PLAYER_A = 1'b0;
  localparam logic PLAYER_B = 1'b1;
endpackage

// File: rtl/ttt_pos_dec.sv
// ttt_pos_dec: cell index to one-hot board mask, with an in-range flag
module ttt_pos_dec
  import ttt_pkg::*;
(
  input  logic [3:0]   i_pos,
  output board_t       o_onehot,
  output logic         o_in_range
);
  assign o_in_range = i_pos < 4'(NUM_CELLS);
  assign o_onehot   = o_in_range ? board_t'(1) << i_pos : '0;
endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: tic-tac-toe move sequencer (PLAY/CHECK/DONE); GAME_SCORE_EN adds saturating win counters
module game_sequencer
  import ttt_pkg::*;
#(
  parameter logic FIRST_PLAYER = PLAYER_A
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 new_game,
  input  logic                 move_valid,
  input  logic [3:0]           move_pos,
  output logic                 move_ready,
  input  logic [NUM_LINES-1:0] win_line,
  output board_t               ain,
  output board_t               bin,
  output logic                 turn,
  output logic                 illegal,
  output logic                 game_over,
  output logic [1:0]           winner,
  output logic [NUM_LINES-1:0] win_q,
  output logic [3:0]           score_a,
  output logic [3:0]           score_b
);
  logic [1:0]           r_state;
  board_t               r_ain, r_bin;
  logic                 r_turn;
  logic [3:0]           r_cnt;
  logic                 r_illegal;
  logic [1:0]           r_winner;
  logic [NUM_LINES-1:0] r_win_q;
  board_t               w_cell;
  logic                 w_in_range, w_req, w_accept, w_win;

  ttt_pos_dec u_dec (
    .i_pos      (move_pos),
    .o_onehot   (w_cell),
    .o_in_range (w_in_range)
  );

  assign w_req    = r_state == ST_PLAY && move_valid;
  assign w_accept = w_req && w_in_range && ~|((r_ain | r_bin) & w_cell);
  assign w_win    = r_state == ST_CHECK && |win_line;

  // Game state: accept moves in PLAY, resolve the outcome one cycle later in CHECK
  always_ff @(posedge clk) begin
    if (reset || new_game) begin
      r_state   <= ST_PLAY;
      r_ain     <= '0;
      r_bin     <= '0;
      r_turn    <= FIRST_PLAYER;
      r_cnt     <= '0;
      r_illegal <= 1'b0;
      r_winner  <= WIN_NONE;
      r_win_q   <= '0;
    end else begin
      r_illegal <= w_req && !w_accept;
      if (w_accept) begin
        if (r_turn) r_bin <= r_bin | w_cell;
        else r_ain <= r_ain | w_cell;
        r_cnt   <= r_cnt + 4'd1;
        r_state <= ST_CHECK;
      end else if (r_state == ST_CHECK) begin
        if (w_win) begin
          r_winner <= r_turn ? WIN_B : WIN_A;
          r_win_q  <= win_line;
          r_state  <= ST_DONE;
        end else if (r_cnt == 4'(NUM_CELLS)) begin
          r_winner <= WIN_DRAW;
          r_win_q  <= '0;
          r_state  <= ST_DONE;
        end else begin
          r_turn  <= ~r_turn;
          r_state <= ST_PLAY;
        end
      end
    end
  end

  assign move_ready = r_state == ST_PLAY;
  assign game_over  = r_state == ST_DONE;
  assign ain        = r_ain;
  assign bin        = r_bin;
  assign turn       = r_turn;
  assign illegal    = r_illegal;
  assign winner     = r_winner;
  assign win_q      = r_win_q;

`ifdef GAME_SCORE_EN
  logic [3:0] r_score_a, r_score_b;
  // Win counters survive new_game and saturate at 15; only reset clears them
  always_ff @(posedge clk) begin
    if (reset) begin
      r_score_a <= '0;
      r_score_b <= '0;
    end else if (!new_game && w_win) begin
      if (!r_turn && r_score_a != 4'hF) r_score_a <= r_score_a + 4'd1;
      if (r_turn && r_score_b != 4'hF) r_score_b <= r_score_b + 4'd1;
    end
  end
  assign score_a = r_score_a;
  assign score_b = r_score_b;
`else
  assign score_a = '0;
  assign score_b = '0;
`endif
endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: vector table, hand sequences and random play against a board-level model
module tb_game_sequencer;
  localparam bit FP = 1'b0;
  logic clk = 1'b0;
  logic reset = 1'b1, new_game = 1'b0, move_valid = 1'b0;
  logic [3:0] move_pos = 4'd0;
  logic [7:0] win_line, w_raw;
  logic move_ready, turn, illegal, game_over;
  logic [8:0] ain, bin;
  logic [1:0] winner;
  logic [7:0] win_q;
  logic [3:0] score_a, score_b;
  int checks = 0, failures = 0;
  int LN [8][3] = '{'{6,7,8}, '{3,4,5}, '{0,1,2}, '{0,3,6}, '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  game_sequencer #(.FIRST_PLAYER(FP)) dut (
    .clk(clk), .reset(reset), .new_game(new_game), .move_valid(move_valid),
    .move_pos(move_pos), .move_ready(move_ready), .win_line(win_line),
    .ain(ain), .bin(bin), .turn(turn), .illegal(illegal), .game_over(game_over),
    .winner(winner), .win_q(win_q), .score_a(score_a), .score_b(score_b)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] lines_of(input logic [8:0] b);
    logic [7:0] r = '0;
    for (int l = 0; l < 8; l++) r[l] = b[LN[l][0]] & b[LN[l][1]] & b[LN[l][2]];
    return r;
  endfunction

  always_comb begin
    w_raw    = lines_of(ain) | lines_of(bin);
    win_line = w_raw & (~w_raw + 8'd1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  int bd [9];
  bit m_turn, m_over, m_ill;
  int m_cnt, sa, sb;
  logic [1:0] m_win;
  logic [7:0] m_wq;

  task automatic m_clear();
    foreach (bd[i]) bd[i] = 0;
    m_turn = FP; m_cnt = 0; m_win = 2'b00; m_wq = 8'h00; m_over = 0;
  endtask

  task automatic m_step(input bit ng, input bit mv, input logic [3:0] p, input bit rst);
    m_ill = 0;
    if (rst) begin
      m_clear(); sa = 0; sb = 0;
    end else if (ng) m_clear();
    else if (mv && !m_over) begin
      if (p > 8) m_ill = 1;
      else if (bd[p] != 0) m_ill = 1;
      else begin
        int mk;
        mk = m_turn ? 2 : 1;
        bd[p] = mk;
        m_cnt++;
        for (int l = 0; l < 8; l++)
          if (m_wq == 0 && bd[LN[l][0]] == mk && bd[LN[l][1]] == mk && bd[LN[l][2]] == mk) m_wq = 8'(1 << l);
        if (m_wq != 0) begin
          m_win = 2'(mk); m_over = 1;
          if (mk == 1) sa = sa < 15 ? sa + 1 : 15;
          else sb = sb < 15 ? sb + 1 : 15;
        end else if (m_cnt == 9) begin
          m_win = 2'b11; m_over = 1;
        end else m_turn = !m_turn;
      end
    end
  endtask

  function automatic logic [8:0] m_board(input int who);
    logic [8:0] r = '0;
    for (int i = 0; i < 9; i++) r[i] = bd[i] == who;
    return r;
  endfunction

  function automatic int exp_score(input int s);
`ifdef GAME_SCORE_EN
    return s;
`else
    return 0;
`endif
  endfunction

  logic s_ill1, s_ill2;

  task automatic drive(input bit ng, input bit mv, input logic [3:0] p, input bit rst);
    @(negedge clk);
    reset = rst; new_game = ng; move_valid = mv; move_pos = p;
    @(negedge clk);
    reset = 0; new_game = 0; move_valid = 0;
    s_ill1 = illegal;
    @(negedge clk);
    s_ill2 = illegal;
  endtask

  task automatic step(input string tag, input bit ng, input bit mv, input logic [3:0] p, input bit rst);
    drive(ng, mv, p, rst);
    m_step(ng, mv, p, rst);
    chk({tag, ".illegal"}, 32'(s_ill1), 32'(m_ill));
    chk({tag, ".illegal_clear"}, 32'(s_ill2), 0);
    chk({tag, ".ain"}, 32'(ain), 32'(m_board(1)));
    chk({tag, ".bin"}, 32'(bin), 32'(m_board(2)));
    chk({tag, ".turn"}, 32'(turn), 32'(m_turn));
    chk({tag, ".game_over"}, 32'(game_over), 32'(m_over));
    chk({tag, ".move_ready"}, 32'(move_ready), 32'(!m_over));
    chk({tag, ".winner"}, 32'(winner), 32'(m_win));
    chk({tag, ".win_q"}, 32'(win_q), 32'(m_wq));
    chk({tag, ".score_a"}, 32'(score_a), exp_score(sa));
    chk({tag, ".score_b"}, 32'(score_b), exp_score(sb));
  endtask

  typedef struct {
    logic ng, mv; logic [3:0] pos; logic ill;
    logic [8:0] a, b; logic t, over; logic [1:0] w; logic [7:0] q;
  } vec_t;
  vec_t tv [15];

  int a_win [5] = '{8, 0, 7, 1, 6};
  int draw [9] = '{4, 0, 8, 2, 1, 7, 6, 3, 5};

  initial begin
    tv[0]  = '{1, 0,  0, 0, 9'h000, 9'h000, 0, 0, 2'b00, 8'h00};
    tv[1]  = '{0, 1,  4, 0, 9'h010, 9'h000, 1, 0, 2'b00, 8'h00};
    tv[2]  = '{0, 1,  4, 1, 9'h010, 9'h000, 1, 0, 2'b00, 8'h00};
    tv[3]  = '{0, 1, 12, 1, 9'h010, 9'h000, 1, 0, 2'b00, 8'h00};
    tv[4]  = '{0, 1,  0, 0, 9'h010, 9'h001, 0, 0, 2'b00, 8'h00};
    tv[5]  = '{0, 1,  9, 1, 9'h010, 9'h001, 0, 0, 2'b00, 8'h00};
    tv[6]  = '{0, 1,  2, 0, 9'h014, 9'h001, 1, 0, 2'b00, 8'h00};
    tv[7]  = '{1, 1,  5, 0, 9'h000, 9'h000, 0, 0, 2'b00, 8'h00};
    tv[8]  = '{0, 1,  8, 0, 9'h100, 9'h000, 1, 0, 2'b00, 8'h00};
    tv[9]  = '{0, 1,  0, 0, 9'h100, 9'h001, 0, 0, 2'b00, 8'h00};
    tv[10] = '{0, 1,  7, 0, 9'h180, 9'h001, 1, 0, 2'b00, 8'h00};
    tv[11] = '{0, 1,  1, 0, 9'h180, 9'h003, 0, 0, 2'b00, 8'h00};
    tv[12] = '{0, 1,  6, 0, 9'h1C0, 9'h003, 0, 1, 2'b01, 8'h01};
    tv[13] = '{0, 1,  2, 0, 9'h1C0, 9'h003, 0, 1, 2'b01, 8'h01};
    tv[14] = '{1, 0,  0, 0, 9'h000, 9'h000, 0, 0, 2'b00, 8'h00};

    drive(0, 0, 0, 1);
    chk("rst.ain", 32'(ain), 0);
    chk("rst.bin", 32'(bin), 0);
    chk("rst.turn", 32'(turn), 32'(FP));
    chk("rst.ready", 32'(move_ready), 1);
    chk("rst.over", 32'(game_over), 0);
    chk("rst.illegal", 32'(illegal), 0);
    chk("rst.winner", 32'(winner), 0);
    chk("rst.win_q", 32'(win_q), 0);
    chk("rst.score_a", 32'(score_a), 0);
    chk("rst.score_b", 32'(score_b), 0);

    for (int i = 0; i < 15; i++) begin
      drive(tv[i].ng, tv[i].mv, tv[i].pos, 0);
      chk($sformatf("tv%0d.illegal", i), 32'(s_ill1), 32'(tv[i].ill));
      chk($sformatf("tv%0d.illegal_clear", i), 32'(s_ill2), 0);
      chk($sformatf("tv%0d.ain", i), 32'(ain), 32'(tv[i].a));
      chk($sformatf("tv%0d.bin", i), 32'(bin), 32'(tv[i].b));
      chk($sformatf("tv%0d.turn", i), 32'(turn), 32'(tv[i].t));
      chk($sformatf("tv%0d.over", i), 32'(game_over), 32'(tv[i].over));
      chk($sformatf("tv%0d.ready", i), 32'(move_ready), 32'(!tv[i].over));
      chk($sformatf("tv%0d.winner", i), 32'(winner), 32'(tv[i].w));
      chk($sformatf("tv%0d.win_q", i), 32'(win_q), 32'(tv[i].q));
    end

    @(negedge clk);
    move_valid = 1; move_pos = 4;
    @(negedge clk);
    move_pos = 3;
    chk("chk.ready_low", 32'(move_ready), 0);
    @(negedge clk);
    move_valid = 0;
    chk("chk.ignored_illegal", 32'(illegal), 0);
    chk("chk.ignored_ain", 32'(ain), 32'(9'h010));
    chk("chk.turn_b", 32'(turn), 1);
    chk("chk.ready_back", 32'(move_ready), 1);
    move_valid = 1; move_pos = 0;
    @(negedge clk);
    reset = 1; new_game = 1; move_pos = 5;
    @(negedge clk);
    reset = 0; new_game = 0; move_valid = 0;
    chk("rstchk.ain", 32'(ain), 0);
    chk("rstchk.bin", 32'(bin), 0);
    chk("rstchk.turn", 32'(turn), 32'(FP));
    chk("rstchk.ready", 32'(move_ready), 1);
    chk("rstchk.illegal", 32'(illegal), 0);

    step("sync", 0, 0, 0, 1);
    for (int g = 0; g < 16; g++) begin
      step("awin.ng", 1, 0, 0, 0);
      foreach (a_win[k]) step("awin", 0, 1, 4'(a_win[k]), 0);
    end
    chk("awin.ain", 32'(ain), 32'(9'h1C0));
    chk("awin.win_q", 32'(win_q), 32'(8'h01));
`ifdef GAME_SCORE_EN
    chk("awin.score_sat", 32'(score_a), 15);
`else
    chk("awin.score_zero", 32'(score_a), 0);
`endif
    step("draw.ng", 1, 0, 0, 0);
    foreach (draw[k]) step("draw", 0, 1, 4'(draw[k]), 0);
    chk("draw.winner", 32'(winner), 32'(2'b11));
    chk("draw.win_q", 32'(win_q), 0);
    chk("draw.over", 32'(game_over), 1);
    step("score.rst", 0, 0, 0, 1);
    chk("score.cleared", 32'(score_a), 0);

    for (int n = 0; n < 500; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r == 0) step("rnd.rst", 0, 1, 4'($urandom_range(0, 15)), 1);
      else if (r < 6 || (m_over && r < 50)) step("rnd.ng", 1, 1'($urandom), 4'($urandom_range(0, 15)), 0);
      else if (r < 80) step("rnd.mv", 0, 1, 4'($urandom_range(0, 8)), 0);
      else step("rnd.mvx", 0, 1'($urandom), 4'($urandom_range(0, 15)), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 SHALL have parameter FIRST_PLAYER, default 0, meaning the player who moves first after reset or new game (0=A, 1=B).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port new_game  input  1  clears the board and starts a new game.
REQ-005 SHALL have port move_valid  input  1  a move request is present this cycle.
REQ-006 SHALL have port move_pos  input  4  requested cell index, 0..8 (bit index into ain/bin).
REQ-007 SHALL have port move_ready  output  1  a move can be accepted this cycle.
REQ-008 SHALL have port win_line  input  8  one-hot winning line from the external winner detector, computed combinationally from ain/bin.
REQ-009 SHALL have ports ain, bin  output  9 each  registered cells held by players A and B.
REQ-010 SHALL have port turn  output  1  player to move next (0=A, 1=B).
REQ-011 SHALL have port illegal  output  1  one-cycle pulse when a move is rejected.
REQ-012 SHALL have port game_over  output  1  high while in DONE.
REQ-013 SHALL have port winner  output  2  00 none, 01 A, 10 B, 11 draw; valid while game_over.
REQ-014 SHALL have port win_q  output  8  win_line captured on entry to DONE.
REQ-015 SHALL have ports score_a, score_b  output  4 each  games won per player (see Configuration).

Function
REQ-016 SHALL implement states PLAY, CHECK, DONE; move_ready=1 only in PLAY.
REQ-017 In PLAY, a move is accepted when move_valid=1, move_pos<=8, and ain[move_pos]|bin[move_pos]=0; the bit of the player given by turn SHALL be set on the next edge and the state SHALL go to CHECK.
REQ-018 A move with move_pos>8 or an occupied cell SHALL leave the board, turn and state unchanged and pulse illegal for exactly one cycle.
REQ-019 move_valid outside PLAY SHALL be ignored without an illegal pulse.
REQ-020 SHALL keep an internal 4-bit move count, incremented per accepted move, range 0..9.
REQ-021 In CHECK (one cycle after acceptance), if win_line!=0 then winner SHALL be set to the player who just moved, win_q SHALL be set to win_line, and the state SHALL go to DONE.
REQ-022 In CHECK, else if the move count is 9, then winner=11, win_q=0, and the state SHALL go to DONE.
REQ-023 In CHECK, otherwise turn SHALL toggle and the state SHALL return to PLAY; move-to-next-move_ready latency is therefore 2 cycles.
REQ-024 DONE SHALL hold the board, winner and win_q until new_game or reset.
REQ-025 new_game=1 in any state SHALL clear the board, count, winner and win_q, set turn=FIRST_PLAYER, and enter PLAY on the next edge; it takes priority over a simultaneous move_valid.

Reset
REQ-026 On reset=1 at a clock edge, the block SHALL enter PLAY with ain=bin=0, turn=FIRST_PLAYER, count=0, illegal=0, game_over=0, winner=00, win_q=0, score_a=score_b=0.
REQ-027 Reset SHALL take priority over new_game and move_valid, including mid-game and in CHECK.

Configuration
REQ-028 With macro GAME_SCORE_EN defined, score_a/score_b SHALL increment by 1 on the CHECK->DONE transition for the corresponding winner, saturate at 15, be unaffected by draws and new_game, and clear only on reset.
REQ-029 Without GAME_SCORE_EN, score_a and score_b SHALL be constant 0 and no score registers SHALL exist.

Structure
REQ-030 A shared package ttt_pkg SHALL hold the state encoding, the winner codes (WIN_NONE, WIN_A, WIN_B, WIN_DRAW), the player codes, and constants NUM_CELLS=9 and NUM_LINES=8.
REQ-031 The index-to-one-hot cell decode SHALL be a sub-module ttt_pos_dec (4-bit index in, 9-bit one-hot plus in_range flag out); the winner detector stays external.

Verification
REQ-032 Reset, then moves 8 (A), 0 (B), 7 (A), 1 (B), 6 (A), with detector attached -> after the last CHECK: game_over=1, winner=01, win_q=8'b00000001, ain=9'h1C0.
REQ-033 Move to pos 4, then another move to pos 4 -> second move gives illegal=1 for one cycle; bin unchanged; turn stays B.
REQ-034 Move with move_pos=12 in PLAY -> illegal pulse; no state change; move_ready stays 1.
REQ-035 Full draw sequence 4,0,8,2,1,7,6,3,5 -> winner=11, win_q=0, game_over=1 after the ninth CHECK.
REQ-036 new_game asserted together with move_valid in PLAY mid-game -> board cleared, move discarded, turn=FIRST_PLAYER.
REQ-037 With GAME_SCORE_EN, 16 consecutive A wins separated by new_game -> score_a saturates at 15; reset -> score_a=0.
